uart_rx_ctrl: RTL and testbench

UART_RX_CTRL -- requirements
Module: uart_rx_ctrl

---
 rtl/uart_rx_ctrl.sv | 187 ++++++++++++++++++
 tb/tb_uart_rx_ctrl.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: arms a UART receiver, captures bytes on ready rising
// edges into a small FIFO and drives RTS with hysteresis.
// Ports:
//   i_divided_clk, i_rst      : clock, async active-high reset
//   i_enable, o_rx_en         : software enable, receiver enable
//   i_rx_data, i_rx_ready     : receiver byte and ready level
//   o_data, o_valid, i_ack    : FIFO head, non-empty, pop strobe
//   o_count                   : FIFO occupancy
//   o_rts_n                   : flow control (0 = sender may send)
//   o_overflow, i_clear_ovf   : sticky drop flag and its clear
//   o_idle                    : no push for IDLE_CYCLES in RUN
module uart_rx_ctrl #(
    parameter int DATA        = 8,
    parameter int DEPTH       = 8,
    parameter int HIGH_WATER  = 6,
    parameter int LOW_WATER   = 2,
    parameter int ARM_CYCLES  = 32,
    parameter int IDLE_CYCLES = 160
) (
    input  logic                   i_divided_clk,
    input  logic                   i_rst,
    input  logic                   i_enable,
    output logic                   o_rx_en,
    input  logic [DATA-1:0]        i_rx_data,
    input  logic                   i_rx_ready,
    output logic [DATA-1:0]        o_data,
    output logic                   o_valid,
    input  logic                   i_ack,
    output logic [$clog2(DEPTH):0] o_count,
    output logic                   o_rts_n,
    output logic                   o_overflow,
    input  logic                   i_clear_ovf,
    output logic                   o_idle
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int MW = $clog2(ARM_CYCLES + 1);
    localparam int IW = $clog2(IDLE_CYCLES + 1);

    typedef enum logic [1:0] {
        OFF,
        ARM,
        RUN
    } state_t;

    state_t          state;
    state_t          state_nx;
    logic [MW-1:0]   arm_cnt;
    logic [IW-1:0]   idle_cnt;
    logic [DATA-1:0] mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [CW-1:0]   count;
    logic [CW-1:0]   count_nx;
    logic            prev_ready;
    logic            rts_n;
    logic            rts_nx;
    logic            overflow;
    logic            arm_done;
    logic            rise;
    logic            full;
    logic            pop;
    logic            wr_en;
    logic            drop;

    assign arm_done = (arm_cnt == MW'(ARM_CYCLES - 1));
    assign rise     = (state == RUN) && i_rx_ready && !prev_ready;
    assign full     = (count == CW'(DEPTH));
    assign pop      = i_ack && (count != '0);
    // A full FIFO still accepts a byte when a pop frees a slot
    // in the same cycle.
    assign wr_en    = rise && (!full || pop);
    assign drop     = rise && full && !pop;

    always_ff @(posedge i_divided_clk or posedge i_rst) begin
        if (i_rst) begin
            state <= OFF;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            OFF: begin
                if (i_enable) state_nx = ARM;
            end
            ARM: begin
                if (!i_enable)     state_nx = OFF;
                else if (arm_done) state_nx = RUN;
            end
            RUN: begin
                if (!i_enable) state_nx = OFF;
            end
            default: state_nx = OFF;
        endcase
    end

    always_ff @(posedge i_divided_clk or posedge i_rst) begin
        if (i_rst) begin
            arm_cnt <= '0;
        end else if (state == ARM && state_nx == ARM) begin
            arm_cnt <= arm_cnt + 1'b1;
        end else begin
            arm_cnt <= '0;
        end
    end

    // Tracking ready every cycle also loads it on RUN entry, so a
    // level left high from an earlier frame is never seen as an edge.
    always_ff @(posedge i_divided_clk or posedge i_rst) begin
        if (i_rst) begin
            prev_ready <= 1'b0;
        end else begin
            prev_ready <= i_rx_ready;
        end
    end

    always_comb begin
        count_nx = count;
        if (wr_en && !pop)      count_nx = count + 1'b1;
        else if (!wr_en && pop) count_nx = count - 1'b1;
    end

    always_ff @(posedge i_divided_clk) begin
        if (wr_en) mem[wr_ptr] <= i_rx_data;
    end

    always_ff @(posedge i_divided_clk or posedge i_rst) begin
        if (i_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (pop)   rd_ptr <= rd_ptr + 1'b1;
            count <= count_nx;
        end
    end

    always_ff @(posedge i_divided_clk or posedge i_rst) begin
        if (i_rst) begin
            overflow <= 1'b0;
        end else if (drop) begin
            overflow <= 1'b1;
        end else if (i_clear_ovf) begin
            overflow <= 1'b0;
        end
    end

    // Between the water marks RTS holds, giving hysteresis.
    always_comb begin
        rts_nx = rts_n;
        if (state_nx != RUN)                   rts_nx = 1'b1;
        else if (count_nx >= CW'(HIGH_WATER)) rts_nx = 1'b1;
        else if (count_nx <= CW'(LOW_WATER))  rts_nx = 1'b0;
    end

    always_ff @(posedge i_divided_clk or posedge i_rst) begin
        if (i_rst) begin
            rts_n <= 1'b1;
        end else begin
            rts_n <= rts_nx;
        end
    end

    always_ff @(posedge i_divided_clk or posedge i_rst) begin
        if (i_rst) begin
            idle_cnt <= '0;
        end else if (state_nx != RUN || state != RUN || rise) begin
            idle_cnt <= '0;
        end else if (idle_cnt != IW'(IDLE_CYCLES)) begin
            idle_cnt <= idle_cnt + 1'b1;
        end
    end

    assign o_rx_en    = (state != OFF);
    assign o_data     = mem[rd_ptr];
    assign o_valid    = (count != '0);
    assign o_count    = count;
    assign o_rts_n    = rts_n;
    assign o_overflow = overflow;
    assign o_idle     = (state == RUN) && (idle_cnt == IW'(IDLE_CYCLES));

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// tb_uart_rx_ctrl: directed and random stimulus for uart_rx_ctrl,
// scored against a queue-based reference model.
module tb_uart_rx_ctrl;

    localparam int DEPTH = 4;
    localparam int HW    = 3;
    localparam int LW    = 1;
    localparam int ARM   = 4;
    localparam int IDLE  = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic       enable;
    logic       rx_en;
    logic [7:0] rx_data;
    logic       rx_ready;
    logic [7:0] data;
    logic       valid;
    logic       ack;
    logic [2:0] count;
    logic       rts_n;
    logic       ovf;
    logic       clr;
    logic       idle;

    uart_rx_ctrl #(
        .DATA(8),
        .DEPTH(DEPTH),
        .HIGH_WATER(HW),
        .LOW_WATER(LW),
        .ARM_CYCLES(ARM),
        .IDLE_CYCLES(IDLE)
    ) dut (
        .i_divided_clk(clk),
        .i_rst(rst),
        .i_enable(enable),
        .o_rx_en(rx_en),
        .i_rx_data(rx_data),
        .i_rx_ready(rx_ready),
        .o_data(data),
        .o_valid(valid),
        .i_ack(ack),
        .o_count(count),
        .o_rts_n(rts_n),
        .o_overflow(ovf),
        .i_clear_ovf(clr),
        .o_idle(idle)
    );

    always #5 clk = ~clk;

    int         n_chk = 0;
    int         n_pass = 0;
    logic [7:0] exp_q[$];
    int         streak;
    bit         prev_rdy;
    bit         m_ovf;
    bit         m_rts;
    int         m_idle;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d want %0d", name, act, exp);
    endtask

    function automatic void model_reset();
        exp_q.delete();
        streak   = 0;
        prev_rdy = 1'b0;
        m_ovf    = 1'b0;
        m_rts    = 1'b1;
        m_idle   = 0;
    endfunction

    // Monitor: every accepted pop must return the oldest expected byte.
    always @(negedge clk) begin
        if (!rst && ack && valid) begin
            chk("pop_expected", int'(exp_q.size() > 0), 1);
            if (exp_q.size() > 0)
                chk("pop_data", int'(data), int'(exp_q.pop_front()));
        end
    end

    // One clock: drive inputs, update the model, check after the edge.
    // Model: RUN once enable has been high for more than ARM edges.
    task automatic cyc(input bit en, input bit rdy,
                       input logic [7:0] d, input bit a, input bit c);
        bit run_now;
        bit run_nx;
        bit push;
        int sz;
        enable   = en;
        rx_ready = rdy;
        rx_data  = d;
        ack      = a;
        clr      = c;
        run_now  = (streak > ARM);
        push     = run_now && rdy && !prev_rdy;
        sz       = exp_q.size();
        if (push && (sz < DEPTH || a)) exp_q.push_back(d);
        if (push && sz == DEPTH && !a) m_ovf = 1'b1;
        else if (c)                     m_ovf = 1'b0;
        prev_rdy = rdy;
        streak   = en ? streak + 1 : 0;
        run_nx   = (streak > ARM);
        @(posedge clk);
        #1;
        sz = exp_q.size();
        if (!run_nx)       m_rts = 1'b1;
        else if (sz >= HW) m_rts = 1'b1;
        else if (sz <= LW) m_rts = 1'b0;
        if (!run_nx || !run_now || push) m_idle = 0;
        else if (m_idle < IDLE)          m_idle++;
        chk("count", int'(count), sz);
        chk("valid", int'(valid), int'(sz > 0));
        chk("rx_en", int'(rx_en), int'(streak > 0));
        chk("rts_n", int'(rts_n), int'(m_rts));
        chk("overflow", int'(ovf), int'(m_ovf));
        chk("idle", int'(idle), int'(run_nx && m_idle == IDLE));
        if (sz > 0) chk("head", int'(data), int'(exp_q[0]));
    endtask

    task automatic pb(input logic [7:0] d, input bit a);
        cyc(1'b1, 1'b0, d, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, d, a, 1'b0);
    endtask

    task automatic ackc();
        cyc(1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
    endtask

    initial begin
        rst      = 1'b1;
        enable   = 1'b0;
        rx_ready = 1'b0;
        rx_data  = 8'h00;
        ack      = 1'b0;
        clr      = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_count", int'(count), 0);
        chk("rst_valid", int'(valid), 0);
        chk("rst_rx_en", int'(rx_en), 0);
        chk("rst_rts_n", int'(rts_n), 1);
        chk("rst_ovf", int'(ovf), 0);
        chk("rst_idle", int'(idle), 0);
        rst = 1'b0;

        // Ready already high while arming: no push.
        cyc(1'b1, 1'b1, 8'h99, 1'b0, 1'b0);
        chk("arm_rx_en", int'(rx_en), 1);
        repeat (ARM + 3) cyc(1'b1, 1'b1, 8'h99, 1'b0, 1'b0);
        chk("stale_ready", int'(count), 0);
        pb(8'hA5, 1'b0);
        chk("first_push", int'(count), 1);
        ackc();

        // Water marks.
        pb(8'h41, 1'b0);
        pb(8'h42, 1'b0);
        pb(8'h43, 1'b0);
        chk("hw_count", int'(count), 3);
        chk("hw_rts", int'(rts_n), 1);
        chk("hw_head", int'(data), 8'h41);
        ackc();
        ackc();
        chk("lw_head", int'(data), 8'h43);
        chk("lw_count", int'(count), 1);
        chk("lw_rts", int'(rts_n), 0);
        ackc();

        // Overflow and clear.
        for (int i = 0; i < 5; i++) pb(8'h10 + 8'(i), 1'b0);
        chk("ovf_count", int'(count), 4);
        chk("ovf_set", int'(ovf), 1);
        cyc(1'b1, 1'b0, 8'h00, 1'b0, 1'b1);
        chk("ovf_clr", int'(ovf), 0);
        repeat (4) ackc();

        // Push and pop together while full.
        for (int i = 0; i < 4; i++) pb(8'h20 + 8'(i), 1'b0);
        pb(8'h55, 1'b1);
        chk("full_pp_count", int'(count), 4);
        chk("full_pp_ovf", int'(ovf), 0);
        repeat (4) ackc();
        chk("drained", int'(count), 0);

        // Push and ack together while empty.
        pb(8'h5A, 1'b1);
        chk("empty_pa", int'(count), 1);
        ackc();

        // Idle timeout, then leaving RUN.
        pb(8'h66, 1'b0);
        repeat (IDLE - 1) cyc(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        chk("idle_early", int'(idle), 0);
        cyc(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        chk("idle_set", int'(idle), 1);
        pb(8'h67, 1'b0);
        chk("idle_clr", int'(idle), 0);
        cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        chk("off_rx_en", int'(rx_en), 0);
        chk("off_rts", int'(rts_n), 1);
        chk("off_keep", int'(count), 2);
        cyc(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        cyc(1'b0, 1'b1, 8'h77, 1'b0, 1'b0);
        chk("off_edge", int'(count), 1);

        // Edge during ARM is ignored; then async reset mid-run.
        cyc(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 8'h88, 1'b0, 1'b0);
        repeat (ARM) cyc(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        chk("arm_edge", int'(count), 1);
        pb(8'h31, 1'b0);
        chk("pre_rst", int'(count), 2);
        enable   = 1'b0;
        rx_ready = 1'b0;
        ack      = 1'b0;
        #1;
        rst = 1'b1;
        #1;
        chk("arst_count", int'(count), 0);
        chk("arst_valid", int'(valid), 0);
        chk("arst_rx_en", int'(rx_en), 0);
        chk("arst_rts", int'(rts_n), 1);
        chk("arst_ovf", int'(ovf), 0);
        chk("arst_idle", int'(idle), 0);
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        cyc(1'b1, 1'b1, 8'h99, 1'b0, 1'b0);
        chk("post_rst", int'(count), 0);

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            cyc($urandom_range(0, 24) != 0,
                1'($urandom_range(0, 1)),
                8'($urandom),
                $urandom_range(0, 2) == 0,
                $urandom_range(0, 7) == 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
